// File: rtl/hazard_tracker.sv
// Load-use / flush / memory-stall hazard tracker holding EX/MEM/WB destination tags; optional counters via HAZARD_TRACKER_STATS_EN.
// Latency: stage tags registered, one cycle per stage; stall_id and bubble_ex are combinational from ID and EX state.
// Backpressure: mem_stall freezes every stage; a load-use hit stalls ID for exactly one cycle while a bubble enters EX.
module hazard_tracker (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [1:0] id_rs,
    input  logic [1:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic [1:0] id_rd,
    input  logic       id_reg_write,
    input  logic       id_mem_read,
    input  logic       flush,
    input  logic       mem_stall,
    output logic [1:0] ex_rd,
    output logic [1:0] mem_rd,
    output logic [1:0] wb_rd,
    output logic       ex_reg_write,
    output logic       mem_reg_write,
    output logic       wb_reg_write,
    output logic       stall_id,
    output logic       bubble_ex
`ifdef HAZARD_TRACKER_STATS_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
`endif
);

    logic ex_mem_read;
    logic load_use;
    logic take_flush;
    logic take_lu;
    logic insert_bubble;

    assign load_use = ex_mem_read & ex_reg_write & id_valid &
                      ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));

    assign take_flush    = ~mem_stall & flush;
    assign take_lu       = ~mem_stall & ~flush & load_use;
    assign insert_bubble = take_flush | take_lu | ~id_valid;

    // Reset gating keeps both strobes low while rst_n is held, whatever mem_stall does.
    assign stall_id  = rst_n & (mem_stall | take_lu);
    assign bubble_ex = rst_n & ~mem_stall & insert_bubble;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rd         <= 2'd0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            mem_rd        <= 2'd0;
            mem_reg_write <= 1'b0;
            wb_rd         <= 2'd0;
            wb_reg_write  <= 1'b0;
        end else if (!mem_stall) begin
            wb_rd         <= mem_rd;
            wb_reg_write  <= mem_reg_write;
            mem_rd        <= ex_rd;
            mem_reg_write <= ex_reg_write;
            if (insert_bubble) begin
                ex_rd        <= 2'd0;
                ex_reg_write <= 1'b0;
                ex_mem_read  <= 1'b0;
            end else begin
                ex_rd        <= id_rd;
                // R0 is never a real destination, so its write-enable is dropped here.
                ex_reg_write <= id_reg_write & (id_rd != 2'd0);
                ex_mem_read  <= id_mem_read;
            end
        end
    end

`ifdef HAZARD_TRACKER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            if (take_lu && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (take_flush && flush_cnt != 16'hFFFF) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_tracker.sv
// Randomized and directed bench for hazard_tracker against a pipeline-shift reference model.
module tb_hazard_tracker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [1:0] id_rs = 2'd0, id_rt = 2'd0, id_rd = 2'd0;
    logic       id_uses_rs = 1'b0, id_uses_rt = 1'b0;
    logic       id_reg_write = 1'b0, id_mem_read = 1'b0;
    logic       flush = 1'b0, mem_stall = 1'b0;
    logic [1:0] ex_rd, mem_rd, wb_rd;
    logic       ex_reg_write, mem_reg_write, wb_reg_write;
    logic       stall_id, bubble_ex;
`ifdef HAZARD_TRACKER_STATS_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    hazard_tracker dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .flush(flush), .mem_stall(mem_stall),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_reg_write(ex_reg_write), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .stall_id(stall_id), .bubble_ex(bubble_ex)
`ifdef HAZARD_TRACKER_STATS_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] rd;
        logic       rw;
        logic       mr;
    } ent_t;

    // pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB
    ent_t pipe[3];
    int   m_stall_cnt, m_flush_cnt;
    int   checks = 0;
    int   failures = 0;
    logic last_stall, last_bubble;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic ent_t bubble();
        ent_t e;
        e.rd = 2'd0; e.rw = 1'b0; e.mr = 1'b0;
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = bubble();
        m_stall_cnt = 0;
        m_flush_cnt = 0;
    endtask

    task automatic check_tags(input string where);
        check({where, "_ex_rd"},  32'(ex_rd),         32'(pipe[0].rd));
        check({where, "_ex_rw"},  32'(ex_reg_write),  32'(pipe[0].rw));
        check({where, "_mem_rd"}, 32'(mem_rd),        32'(pipe[1].rd));
        check({where, "_mem_rw"}, 32'(mem_reg_write), 32'(pipe[1].rw));
        check({where, "_wb_rd"},  32'(wb_rd),         32'(pipe[2].rd));
        check({where, "_wb_rw"},  32'(wb_reg_write),  32'(pipe[2].rw));
`ifdef HAZARD_TRACKER_STATS_EN
        check({where, "_stall_cnt"}, 32'(stall_cnt), 32'(m_stall_cnt));
        check({where, "_flush_cnt"}, 32'(flush_cnt), 32'(m_flush_cnt));
`endif
    endtask

    // One clock: apply ID/control inputs, check the combinational strobes, clock, check tags.
    task automatic step(input logic v, input logic [1:0] rs, input logic urs,
                        input logic [1:0] rt, input logic urt,
                        input logic [1:0] rd, input logic rw, input logic mr,
                        input logic fl, input logic ms);
        bit   hit, exp_stall, exp_bubble;
        ent_t nxt;
        id_valid = v; id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr; flush = fl; mem_stall = ms;
        #1;
        hit = pipe[0].mr && pipe[0].rw && v && ((urs && rs == pipe[0].rd) || (urt && rt == pipe[0].rd));
        exp_stall  = ms || (hit && !fl);
        exp_bubble = !ms && (fl || hit || !v);
        last_stall  = stall_id;
        last_bubble = bubble_ex;
        check("stall_id", 32'(stall_id), 32'(exp_stall));
        check("bubble_ex", 32'(bubble_ex), 32'(exp_bubble));
        @(posedge clk);
        if (!ms) begin
            if (exp_bubble) nxt = bubble();
            else begin
                nxt.rd = rd; nxt.rw = rw && (rd != 2'd0); nxt.mr = mr;
            end
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = nxt;
            if (fl && m_flush_cnt < 65535) m_flush_cnt++;
            else if (!fl && hit && m_stall_cnt < 65535) m_stall_cnt++;
        end
        #1;
        check_tags("step");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_stall", 32'(stall_id), 32'(0));
        check("rst_bubble", 32'(bubble_ex), 32'(0));
        check_tags("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        last_stall = 1'b0;
        last_bubble = 1'b0;
        model_reset();
        mem_stall = 1'b1;   // reset must mask stall_id even with mem_stall high
        #2;
        do_reset();
        mem_stall = 1'b0;
        check_tags("post_rst");

        // Advance through EX, MEM, WB
        step(1, 0, 0, 0, 0, 2'd1, 1, 0, 0, 0);
        check("adv_ex", 32'({ex_rd, ex_reg_write}), 32'({2'd1, 1'b1}));
        idle(1);
        check("adv_mem", 32'({mem_rd, mem_reg_write}), 32'({2'd1, 1'b1}));
        idle(1);
        check("adv_wb", 32'({wb_rd, wb_reg_write}), 32'({2'd1, 1'b1}));

        // Load-use on R2 via rs
        step(1, 0, 0, 0, 0, 2'd2, 1, 1, 0, 0);
        step(1, 2'd2, 1, 0, 0, 2'd3, 1, 0, 0, 0);
        check("lu_stall", 32'(last_stall), 32'(1));
        check("lu_bubble", 32'(last_bubble), 32'(1));
        check("lu_mem_rd", 32'(mem_rd), 32'(2));
        step(1, 2'd2, 1, 0, 0, 2'd3, 1, 0, 0, 0);
        check("lu_clear", 32'(last_stall), 32'(0));

        // Flush overrides load-use
        step(1, 0, 0, 0, 0, 2'd2, 1, 1, 0, 0);
        step(1, 0, 0, 2'd2, 1, 2'd3, 1, 0, 1, 0);
        check("fl_stall", 32'(last_stall), 32'(0));
        check("fl_ex_rw", 32'(ex_reg_write), 32'(0));

        // mem_stall freezes 01/10/11
        step(1, 0, 0, 0, 0, 2'd3, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 2'd2, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 2'd1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 0, 2'd2, 1, 0, 0, 1);
            check("ms_stall", 32'(last_stall), 32'(1));
            check("ms_tags", 32'({ex_rd, mem_rd, wb_rd}), 32'({2'd1, 2'd2, 2'd3}));
        end

        // R0 write masked
        step(1, 0, 0, 0, 0, 2'd0, 1, 0, 0, 0);
        check("r0_rw", 32'(ex_reg_write), 32'(0));

        // Reset asserted mid-stall with a load in EX
        step(1, 0, 0, 0, 0, 2'd2, 1, 1, 0, 0);
        step(1, 2'd2, 1, 0, 0, 2'd1, 1, 0, 0, 1);
        do_reset();
        step(1, 2'd2, 1, 0, 0, 2'd1, 1, 0, 0, 0);
        check("rst_no_stall", 32'(last_stall), 32'(0));

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(3, 0) != 0,
                 2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
                 2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
                 2'($urandom_range(3, 0)), $urandom_range(3, 0) != 0,
                 1'($urandom_range(1, 0)),
                 $urandom_range(7, 0) == 0, $urandom_range(7, 0) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
